// File: rtl/add_join_unit.sv
// add_join_unit: waits for one vector from every enabled source, adds the
// vectors lane-wise in fixed point (saturating or wrapping), zeroes unused
// lanes, and queues the result in a first-word fall-through output FIFO.
// Source readiness is gated by a credit check, so a vector that has been
// accepted always has a FIFO slot reserved. The block also counts the
// vectors accepted downstream and pulses frame_done when a frame completes.
module add_join_unit #(
  parameter int                 NUM_SRC     = 3,
  parameter logic [NUM_SRC-1:0] SRC_EN      = '1,
  parameter int                 XW          = 16,
  parameter int                 QW          = 16,
  parameter int                 VALID_CHANS = XW,
  parameter int                 SAT         = 1,
  parameter int                 FIFO_DEPTH  = 4,
  parameter int                 FRAME_LEN   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SRC-1:0][XW-1:0][QW-1:0]    src_data_i,
  input  logic [NUM_SRC-1:0]                    src_valid_i,
  output logic [NUM_SRC-1:0]                    src_ready_o,
  output logic [XW-1:0][QW-1:0]                 data_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic                                  frame_done,
  output logic [$clog2(FRAME_LEN+1)-1:0]        vec_cnt
);

  // Guard width so that the sum of all sources cannot overflow before clamping.
  localparam int SW   = QW + $clog2(NUM_SRC) + 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int OW   = AW + 2;
  localparam int VCW  = $clog2(FRAME_LEN + 1);

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-QW+1){1'b0}}, {(QW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-QW+1){1'b1}}, {(QW-1){1'b0}}};

  if (SRC_EN == '0) begin : g_bad_src_en
    $error("add_join_unit: SRC_EN must enable at least one source");
  end
  if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
    $error("add_join_unit: NUM_SRC must be in 1..8");
  end
  if (VALID_CHANS < 1 || VALID_CHANS > XW) begin : g_bad_chans
    $error("add_join_unit: VALID_CHANS must be in 1..XW");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("add_join_unit: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("add_join_unit: FRAME_LEN must be at least 1");
  end

  // Reduce a guard-width lane sum to QW bits: clamp when SAT, else keep low bits.
  function automatic logic signed [QW-1:0] sat_lane(input logic signed [SW-1:0] v);
    logic signed [QW-1:0] r;
    if (SAT == 0) begin
      r = $signed(v[QW-1:0]);
    end else if (v > SAT_MAX) begin
      r = $signed(SAT_MAX[QW-1:0]);
    end else if (v < SAT_MIN) begin
      r = $signed(SAT_MIN[QW-1:0]);
    end else begin
      r = $signed(v[QW-1:0]);
    end
    return r;
  endfunction

  logic                  all_v;
  logic                  credit_ok;
  logic                  fire;
  logic                  push;
  logic                  pop;
  logic [OW-1:0]         occ;
  logic [CW-1:0]         fifo_count;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [XW-1:0][QW-1:0] fifo_mem [FIFO_DEPTH];

  logic signed [SW-1:0]  sum_c  [XW];
  logic signed [SW-1:0]  sum_p1 [XW];
  logic                  vld_p1;
  logic signed [QW-1:0]  res_p2 [XW];
  logic                  vld_p2;
  logic [XW-1:0][QW-1:0] res_vec_p2;

  // Join and credit: a pop this cycle already frees its slot for a new fire.
  assign all_v     = &(src_valid_i | ~SRC_EN);
  assign pop       = valid_o & ready_i;
  assign push      = vld_p2;
  assign occ       = OW'(fifo_count) + OW'(vld_p1) + OW'(vld_p2) - OW'(pop);
  assign credit_ok = occ < OW'(FIFO_DEPTH);
  assign fire      = all_v & credit_ok & ~rst;

  assign src_ready_o = SRC_EN & {NUM_SRC{fire}};

  // ---- stage 0 -> 1: sign-extended lane sums over enabled sources
  // Lane-wise sum of enabled sources; unused lanes are held at zero.
  always_comb begin
    for (int l = 0; l < XW; l++) begin
      sum_c[l] = '0;
      if (l < VALID_CHANS) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (SRC_EN[s]) begin
            sum_c[l] = sum_c[l] + SW'($signed(src_data_i[s][l]));
          end
        end
      end
    end
  end

  // Datapath registers: stage-1 sums, stage-2 reduced lanes, FIFO storage.
  always_ff @(posedge clk) begin
    if (fire) begin
      sum_p1 <= sum_c;
    end
    // ---- stage 1 -> 2: saturate or wrap to QW bits
    for (int l = 0; l < XW; l++) begin
      res_p2[l] <= sat_lane(sum_p1[l]);
    end
    // ---- stage 2 -> FIFO
    if (push) begin
      fifo_mem[wr_ptr] <= res_vec_p2;
    end
  end

  // Repack the stage-2 lanes into the FIFO word layout.
  always_comb begin
    res_vec_p2 = '0;
    for (int l = 0; l < XW; l++) begin
      res_vec_p2[l] = res_p2[l];
    end
  end

  // Control state: pipeline valids, FIFO pointers/occupancy, frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      vec_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      vld_p1 <= fire;
      vld_p2 <= vld_p1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      frame_done <= 1'b0;
      if (pop) begin
        if (vec_cnt == VCW'(FRAME_LEN - 1)) begin
          vec_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          vec_cnt <= vec_cnt + 1'b1;
        end
      end
    end
  end

  // FIFO head is shown only while valid so an empty queue presents zeros.
  assign valid_o = (fifo_count != '0);
  assign data_o  = valid_o ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_add_join_unit.sv
// tb_add_join_unit: directed table of lane sums plus hand-written sequences
// for join skew, disabled sources, back-pressure, frame counting and reset.
module tb_add_join_unit;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [2:0][15:0][15:0] src_data;
  logic [2:0]             src_valid;
  logic                   ready;
  logic [2:0]             en_valid;
  logic                   en_ready;

  logic [2:0]             s_ready;
  logic [15:0][15:0]      s_data;
  logic                   s_valid;
  logic                   s_fd;
  logic [4:0]             s_cnt;

  logic [2:0]             w_ready;
  logic [15:0][15:0]      w_data;
  logic                   w_valid;
  logic                   w_fd;
  logic [4:0]             w_cnt;

  logic [2:0]             e_ready;
  logic [15:0][15:0]      e_data;
  logic                   e_valid;
  logic                   e_fd;
  logic [4:0]             e_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_join_unit #(.NUM_SRC(3), .XW(16), .QW(16), .VALID_CHANS(10), .SAT(1),
                  .FIFO_DEPTH(4), .FRAME_LEN(16)) dut (
    .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(src_valid),
    .src_ready_o(s_ready), .data_o(s_data), .valid_o(s_valid), .ready_i(ready),
    .frame_done(s_fd), .vec_cnt(s_cnt));

  add_join_unit #(.NUM_SRC(3), .XW(16), .QW(16), .VALID_CHANS(10), .SAT(0),
                  .FIFO_DEPTH(4), .FRAME_LEN(16)) dut_w (
    .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(src_valid),
    .src_ready_o(w_ready), .data_o(w_data), .valid_o(w_valid), .ready_i(ready),
    .frame_done(w_fd), .vec_cnt(w_cnt));

  add_join_unit #(.NUM_SRC(3), .SRC_EN(3'b101), .XW(16), .QW(16), .SAT(1),
                  .FIFO_DEPTH(4), .FRAME_LEN(16)) dut_en (
    .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(en_valid),
    .src_ready_o(e_ready), .data_o(e_data), .valid_o(e_valid), .ready_i(en_ready),
    .frame_done(e_fd), .vec_cnt(e_cnt));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
  } vec_t;

  vec_t tbl [7];
  logic [255:0] expq [$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [15:0] v);
    for (int l = 0; l < 16; l++) src_data[s][l] = v;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] msat(input int s);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [255:0] model(input logic [2:0][15:0][15:0] d);
    logic [15:0][15:0] r;
    int s;
    r = '0;
    for (int l = 0; l < 10; l++) begin
      s = $signed(d[0][l]) + $signed(d[1][l]) + $signed(d[2][l]);
      r[l] = msat(s);
    end
    return r;
  endfunction

  task automatic new_data;
    for (int s = 0; s < 3; s++)
      for (int l = 0; l < 16; l++)
        src_data[s][l] = 16'($urandom);
  endtask

  initial begin
    int fires;
    int fires2;
    int pops;
    int pulses;
    logic exp_fd;
    logic p;
    logic need_new;

    tbl[0] = '{16'd100,   16'hFFE2, 16'd5,    16'h004B, 16'h004B};
    tbl[1] = '{16'd30000, 16'd30000, 16'd0,   16'h7FFF, 16'hEA60};
    tbl[2] = '{16'h8AD0,  16'h8AD0, 16'd0,    16'h8000, 16'h15A0};
    tbl[3] = '{16'hFFFF,  16'hFFFF, 16'hFFFF, 16'hFFFD, 16'hFFFD};
    tbl[4] = '{16'h7FFF,  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFD};
    tbl[5] = '{16'h8000,  16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tbl[6] = '{16'd0,     16'd0,    16'd0,    16'h0000, 16'h0000};

    rst = 1'b1; src_valid = '0; en_valid = '0; ready = 1'b1; en_ready = 1'b1;
    src_data = '0;
    tick(); tick();
    // reset state, with valids asserted while reset is still held
    src_valid = 3'b111;
    #1;
    chk("rst_ready", s_ready, 3'b000);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_data", s_data, '0);
    chk("rst_fd", s_fd, 1'b0);
    chk("rst_cnt", s_cnt, 5'd0);
    src_valid = '0;
    rst = 1'b0;
    tick();

    // table-driven sums: latency, saturation, wrap and masked lanes
    for (int i = 0; i < 7; i++) begin
      set_src(0, tbl[i].a); set_src(1, tbl[i].b); set_src(2, tbl[i].c);
      src_valid = 3'b111;
      #1;
      chk("tbl_ready", s_ready, 3'b111);
      tick();
      src_valid = '0;
      chk("tbl_lat1", s_valid, 1'b0);
      tick();
      chk("tbl_lat2", s_valid, 1'b0);
      tick();
      chk("tbl_valid", s_valid, 1'b1);
      chk("tbl_sat_l0", s_data[0], tbl[i].exp_sat);
      chk("tbl_sat_l9", s_data[9], tbl[i].exp_sat);
      chk("tbl_mask_l10", s_data[10], 16'h0);
      chk("tbl_mask_l15", s_data[15], 16'h0);
      chk("tbl_wrap_l0", w_data[0], tbl[i].exp_wrap);
      tick();
      chk("tbl_drained", s_valid, 1'b0);
    end

    // join skew: ready only once all three sources are valid
    do_reset();
    set_src(0, 16'd1); set_src(1, 16'd2); set_src(2, 16'd3);
    for (int c = 0; c < 8; c++) begin
      src_valid = {c >= 7, c >= 3, 1'b1};
      #1;
      chk("skew_ready", s_ready, (c == 7) ? 3'b111 : 3'b000);
      tick();
    end
    src_valid = '0;
    #1;
    chk("skew_after", s_ready, 3'b000);
    tick(); tick();
    chk("skew_data", s_data[0], 16'd6);
    tick();

    // disabled source 1 is ignored by the SRC_EN=101 instance
    set_src(0, 16'd100); set_src(1, 16'hFFE2); set_src(2, 16'd5);
    en_valid = 3'b001;
    #1;
    chk("en_partial", e_ready, 3'b000);
    tick();
    en_valid = 3'b101;
    #1;
    chk("en_ready", e_ready, 3'b101);
    tick();
    en_valid = '0;
    tick(); tick();
    chk("en_valid", e_valid, 1'b1);
    chk("en_l0", e_data[0], 16'd105);
    chk("en_l15", e_data[15], 16'd105);
    tick();

    // back-pressure: exactly FIFO_DEPTH fires, then one more per pop
    do_reset();
    ready = 1'b0; src_valid = 3'b111; fires = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (s_ready == 3'b111) fires++;
      tick();
    end
    chk("bp_fires", fires, 4);
    #1;
    chk("bp_stalled", s_ready, 3'b000);
    ready = 1'b1;
    fires2 = 0;
    #1;
    if (s_ready == 3'b111) fires2++;
    tick();
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (s_ready == 3'b111) fires2++;
      tick();
    end
    chk("bp_one_more", fires2, 1);
    src_valid = '0;

    // random stalls and skewed valids against a reference queue
    do_reset();
    expq.delete();
    fires = 0; pops = 0; need_new = 1'b1;
    for (int c = 0; c < 20000 && pops < 1000; c++) begin
      if (need_new) new_data();
      need_new = 1'b0;
      if (fires < 1000)
        for (int s = 0; s < 3; s++) src_valid[s] = ($urandom_range(3) != 0);
      else
        src_valid = '0;
      ready = ($urandom_range(4) > 1);
      #1;
      if (s_valid && ready) begin
        if (expq.size() == 0) chk("sb_underflow", s_data, '1);
        else chk("sb_data", s_data, expq.pop_front());
        pops++;
      end
      if (src_valid != 3'b111) chk("sb_no_partial", s_ready, 3'b000);
      if (s_ready == 3'b111) begin
        expq.push_back(model(src_data));
        fires++;
        need_new = 1'b1;
      end
      tick();
    end
    chk("sb_pops", pops, 1000);
    chk("sb_left", expq.size(), 0);
    src_valid = '0;

    // frame counting over 48 vectors at full throughput
    do_reset();
    ready = 1'b1; fires = 0; pops = 0; pulses = 0; exp_fd = 1'b0;
    for (int c = 0; c < 60; c++) begin
      src_valid = (fires < 48) ? 3'b111 : 3'b000;
      #1;
      chk("fr_done", s_fd, exp_fd);
      if (s_fd) pulses++;
      chk("fr_cnt", s_cnt, 5'(pops % 16));
      p = s_valid & ready;
      if (p) pops++;
      exp_fd = p && (pops % 16 == 0);
      if (s_ready == 3'b111) fires++;
      tick();
    end
    chk("fr_pulses", pulses, 3);
    chk("fr_pops", pops, 48);

    // reset mid-frame with vectors buffered
    do_reset();
    ready = 1'b1; fires = 0;
    for (int c = 0; c < 10; c++) begin
      src_valid = (fires < 5) ? 3'b111 : 3'b000;
      #1;
      if (s_ready == 3'b111) fires++;
      tick();
    end
    chk("mr_cnt5", s_cnt, 5'd5);
    ready = 1'b0; fires = 0;
    for (int c = 0; c < 6; c++) begin
      src_valid = (fires < 3) ? 3'b111 : 3'b000;
      #1;
      if (s_ready == 3'b111) fires++;
      tick();
    end
    chk("mr_buffered", s_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", s_valid, 1'b0);
    chk("mr_cnt", s_cnt, 5'd0);
    chk("mr_data", s_data, '0);
    chk("mr_fd", s_fd, 1'b0);
    ready = 1'b1; fires = 0; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      src_valid = (fires < 16) ? 3'b111 : 3'b000;
      #1;
      if (s_fd) pulses++;
      if (s_ready == 3'b111) fires++;
      tick();
    end
    chk("mr_pulses", pulses, 1);
    chk("mr_cnt_end", s_cnt, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
